// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : riscv_pkg                                                   |
// | Brief  : RV32I opcode, funct3 and ALU-operation constants            |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package riscv_pkg;

  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_op_imm = 7'b0010011;
  localparam logic [6:0] c_opc_op     = 7'b0110011;

  localparam logic [2:0] c_f3_add  = 3'b000;
  localparam logic [2:0] c_f3_sll  = 3'b001;
  localparam logic [2:0] c_f3_slt  = 3'b010;
  localparam logic [2:0] c_f3_sltu = 3'b011;
  localparam logic [2:0] c_f3_xor  = 3'b100;
  localparam logic [2:0] c_f3_sr   = 3'b101;
  localparam logic [2:0] c_f3_or   = 3'b110;

  localparam logic [2:0] c_f3_beq  = 3'b000;
  localparam logic [2:0] c_f3_bne  = 3'b001;
  localparam logic [2:0] c_f3_blt  = 3'b100;
  localparam logic [2:0] c_f3_bge  = 3'b101;
  localparam logic [2:0] c_f3_bltu = 3'b110;
  localparam logic [2:0] c_f3_bgeu = 3'b111;

  localparam logic [2:0] c_f3_word = 3'b010;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  // alt is instruction bit 30; SUB only exists in the register-register form
  function automatic alu_op_t alu_op_decode(input logic [2:0] funct3,
                                            input logic alt,
                                            input logic reg_op);
    alu_op_t op;
    case (funct3)
      c_f3_add:  op = (reg_op && alt) ? ALU_SUB : ALU_ADD;
      c_f3_sll:  op = ALU_SLL;
      c_f3_slt:  op = ALU_SLT;
      c_f3_sltu: op = ALU_SLTU;
      c_f3_xor:  op = ALU_XOR;
      c_f3_sr:   op = alt ? ALU_SRA : ALU_SRL;
      c_f3_or:   op = ALU_OR;
      default:   op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : riscv_alu                                                   |
// | Brief  : RV32I integer ALU, mod-2^N arithmetic, 5-bit shift amounts  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module riscv_alu
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  alu_op_t               op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result
);

  logic [4:0] w_shamt;
  assign w_shamt = b[4:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << w_shamt;
      ALU_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> w_shamt;
      ALU_SRA:  result = DATA_WIDTH'($signed(a) >>> w_shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/risc_v_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : risc_v_core                                                 |
// | Brief  : two-stage (IF, EX/WB) RV32I subset core with local memories |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module risc_v_core
  import riscv_pkg::*;
#(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int INDEX_BITS   = 6,
  parameter int OFFSET_BITS  = 3,
  parameter int ADDRESS_BITS = 12
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [19:0]             prog_address,
  input  logic                    isp_write,
  input  logic [ADDRESS_BITS-1:0] isp_address,
  input  logic [DATA_WIDTH-1:0]   isp_data,
  input  logic [1:0]              from_peripheral,
  input  logic [31:0]             from_peripheral_data,
  input  logic                    from_peripheral_valid,
  output logic [1:0]              to_peripheral,
  output logic [31:0]             to_peripheral_data,
  output logic                    to_peripheral_valid,
  input  logic                    report
);

  localparam int c_mem_words = 1 << ADDRESS_BITS;

  logic [DATA_WIDTH-1:0] program_memory [c_mem_words];
  logic [DATA_WIDTH-1:0] data_memory    [c_mem_words];
  logic [DATA_WIDTH-1:0] register_file  [32];

  logic [DATA_WIDTH-1:0] r_pc;
  logic                  r_running;
  logic                  r_if_valid;
  logic [DATA_WIDTH-1:0] r_if_instr;
  logic [DATA_WIDTH-1:0] r_if_pc;
  logic [31:0]           r_cycle_count;
  logic [31:0]           r_retired_count;

  logic [6:0]            w_opcode;
  logic [4:0]            w_rd, w_rs1, w_rs2;
  logic [2:0]            w_funct3;
  logic [6:0]            w_funct7;
  logic [DATA_WIDTH-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [DATA_WIDTH-1:0] w_rs1_val, w_rs2_val, w_link;
  logic [DATA_WIDTH-1:0] w_alu_b, w_alu_result, w_wb_data, w_target;
  logic [ADDRESS_BITS-1:0] w_dm_index;
  alu_op_t               w_alu_op;
  logic                  w_rf_we, w_dm_we, w_taken, w_legal_f7;
  logic                  w_ex_valid, w_rf_write, w_dm_write, w_redirect;
  logic                  w_unused;

  assign to_peripheral       = '0;
  assign to_peripheral_data  = '0;
  assign to_peripheral_valid = 1'b0;
  assign w_unused = ^{from_peripheral, from_peripheral_data, from_peripheral_valid,
                      INDEX_BITS[0], OFFSET_BITS[0]};

  assign w_opcode = r_if_instr[6:0];
  assign w_rd     = r_if_instr[11:7];
  assign w_funct3 = r_if_instr[14:12];
  assign w_rs1    = r_if_instr[19:15];
  assign w_rs2    = r_if_instr[24:20];
  assign w_funct7 = r_if_instr[31:25];

  assign w_imm_i = {{20{r_if_instr[31]}}, r_if_instr[31:20]};
  assign w_imm_s = {{20{r_if_instr[31]}}, r_if_instr[31:25], r_if_instr[11:7]};
  assign w_imm_b = {{19{r_if_instr[31]}}, r_if_instr[31], r_if_instr[7],
                    r_if_instr[30:25], r_if_instr[11:8], 1'b0};
  assign w_imm_u = {r_if_instr[31:12], 12'b0};
  assign w_imm_j = {{11{r_if_instr[31]}}, r_if_instr[31], r_if_instr[19:12],
                    r_if_instr[20], r_if_instr[30:21], 1'b0};

  // Write-back lands on the EX edge, so the next instruction's read already sees it
  assign w_rs1_val  = (w_rs1 == 5'd0) ? '0 : register_file[w_rs1];
  assign w_rs2_val  = (w_rs2 == 5'd0) ? '0 : register_file[w_rs2];
  assign w_link     = r_if_pc + DATA_WIDTH'(4);
  assign w_dm_index = w_alu_result[ADDRESS_BITS+1:2];

  always_comb begin
    w_alu_b  = w_imm_i;
    w_alu_op = ALU_ADD;
    case (w_opcode)
      c_opc_op_imm: w_alu_op = alu_op_decode(w_funct3, r_if_instr[30], 1'b0);
      c_opc_op: begin
        w_alu_b  = w_rs2_val;
        w_alu_op = alu_op_decode(w_funct3, r_if_instr[30], 1'b1);
      end
      c_opc_store:  w_alu_b = w_imm_s;
      default:      ;
    endcase
  end

  riscv_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op     (w_alu_op),
    .a      (w_rs1_val),
    .b      (w_alu_b),
    .result (w_alu_result)
  );

  // funct7 may only be nonzero for SUB/SRA (and must be zero for immediate shifts)
  always_comb begin
    w_legal_f7 = 1'b1;
    if (w_opcode == c_opc_op)
      w_legal_f7 = (w_funct7 == 7'h00) ||
                   ((w_funct7 == 7'h20) && ((w_funct3 == c_f3_add) || (w_funct3 == c_f3_sr)));
    else if (w_funct3 == c_f3_sll)
      w_legal_f7 = (w_funct7 == 7'h00);
    else if (w_funct3 == c_f3_sr)
      w_legal_f7 = (w_funct7 == 7'h00) || (w_funct7 == 7'h20);
  end

  always_comb begin
    w_rf_we   = 1'b0;
    w_dm_we   = 1'b0;
    w_taken   = 1'b0;
    w_wb_data = w_alu_result;
    w_target  = r_if_pc + w_imm_b;
    case (w_opcode)
      c_opc_lui: begin
        w_rf_we   = 1'b1;
        w_wb_data = w_imm_u;
      end
      c_opc_auipc: begin
        w_rf_we   = 1'b1;
        w_wb_data = r_if_pc + w_imm_u;
      end
      c_opc_op_imm, c_opc_op: w_rf_we = w_legal_f7;
      c_opc_jal: begin
        w_rf_we   = 1'b1;
        w_wb_data = w_link;
        w_taken   = 1'b1;
        w_target  = r_if_pc + w_imm_j;
      end
      c_opc_jalr: begin
        w_rf_we   = (w_funct3 == 3'b000);
        w_taken   = (w_funct3 == 3'b000);
        w_wb_data = w_link;
        w_target  = {w_alu_result[DATA_WIDTH-1:1], 1'b0};
      end
      c_opc_branch: begin
        case (w_funct3)
          c_f3_beq:  w_taken = (w_rs1_val == w_rs2_val);
          c_f3_bne:  w_taken = (w_rs1_val != w_rs2_val);
          c_f3_blt:  w_taken = ($signed(w_rs1_val) <  $signed(w_rs2_val));
          c_f3_bge:  w_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
          c_f3_bltu: w_taken = (w_rs1_val <  w_rs2_val);
          c_f3_bgeu: w_taken = (w_rs1_val >= w_rs2_val);
          default:   w_taken = 1'b0;
        endcase
      end
      c_opc_load: begin
        w_rf_we   = (w_funct3 == c_f3_word);
        w_wb_data = data_memory[w_dm_index];
      end
      c_opc_store: w_dm_we = (w_funct3 == c_f3_word);
      default:     ;
    endcase
  end

  // A restart pulse squashes whatever sits in EX that cycle
  assign w_ex_valid = r_if_valid & ~start;
  assign w_rf_write = w_ex_valid & w_rf_we & (w_rd != 5'd0);
  assign w_dm_write = w_ex_valid & w_dm_we;
  assign w_redirect = w_ex_valid & w_taken;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc            <= '0;
      r_running       <= 1'b0;
      r_if_valid      <= 1'b0;
      r_if_instr      <= '0;
      r_if_pc         <= '0;
      r_cycle_count   <= '0;
      r_retired_count <= '0;
    end else begin
      if (r_running) r_cycle_count <= r_cycle_count + 32'd1;
      if (w_ex_valid) r_retired_count <= r_retired_count + 32'd1;
      if (start) begin
        r_pc       <= {{(DATA_WIDTH-20){1'b0}}, prog_address};
        r_running  <= 1'b1;
        r_if_valid <= 1'b0;
      end else if (r_running) begin
        if (w_redirect) begin
          r_pc       <= w_target;
          r_if_valid <= 1'b0;
        end else begin
          r_if_instr <= program_memory[r_pc[ADDRESS_BITS+1:2]];
          r_if_pc    <= r_pc;
          r_if_valid <= 1'b1;
          r_pc       <= r_pc + DATA_WIDTH'(4);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (isp_write) program_memory[isp_address] <= isp_data;
  end

  always_ff @(posedge clock) begin
    if (w_dm_write) data_memory[w_dm_index] <= w_rs2_val;
  end

  always_ff @(posedge clock) begin
    if (w_rf_write) register_file[w_rd] <= w_wb_data;
  end

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (report)
      $display("core %0d: cycles=%0d retired=%0d", CORE, r_cycle_count, r_retired_count);
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_risc_v_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_risc_v_core                                              |
// | Brief  : directed self-checking bench for risc_v_core                |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_risc_v_core;

  logic        clock = 1'b0;
  logic        reset, start, isp_write, from_peripheral_valid, report;
  logic [19:0] prog_address;
  logic [11:0] isp_address;
  logic [31:0] isp_data, from_peripheral_data, to_peripheral_data;
  logic [1:0]  from_peripheral, to_peripheral;
  logic        to_peripheral_valid;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] prog [$];
  logic [31:0] exp_regs [32];

  always #5 clock = ~clock;

  risc_v_core #(
    .CORE(0), .DATA_WIDTH(32), .INDEX_BITS(6), .OFFSET_BITS(3), .ADDRESS_BITS(12)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .prog_address(prog_address),
    .isp_write(isp_write), .isp_address(isp_address), .isp_data(isp_data),
    .from_peripheral(from_peripheral), .from_peripheral_data(from_peripheral_data),
    .from_peripheral_valid(from_peripheral_valid), .to_peripheral(to_peripheral),
    .to_peripheral_data(to_peripheral_data), .to_peripheral_valid(to_peripheral_valid),
    .report(report)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [11:0] addr, input logic [31:0] word);
    isp_address = addr;
    isp_data    = word;
    isp_write   = 1'b1;
    tick(1);
    isp_write   = 1'b0;
  endtask

  task automatic load_prog(input logic [11:0] base);
    for (int i = 0; i < prog.size(); i++) load_word(base + 12'(i), prog[i]);
  endtask

  task automatic do_start(input logic [19:0] addr);
    prog_address = addr;
    start        = 1'b1;
    tick(1);
    start        = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check(tag, {29'd0, to_peripheral, to_peripheral_valid}, 32'd0);
    check(tag, to_peripheral_data, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; prog_address = '0; report = 1'b0;
    isp_write = 1'b0; isp_address = '0; isp_data = '0;
    from_peripheral = 2'b11; from_peripheral_data = 32'hdeadbeef; from_peripheral_valid = 1'b1;
    tick(2);
    check("reset_pc", dut.r_pc, 32'd0);
    check("reset_running", {31'd0, dut.r_running}, 32'd0);
    check_outputs("reset_outputs");
    reset = 1'b0;
    tick(1);

    // zero x1..x31 so later expectations start from a known register file
    for (int i = 0; i < 31; i++) load_word(12'(i), 32'((i + 1) << 7) | 32'h13);
    load_word(12'd31, 32'h0000006f);
    do_start(20'd0);
    tick(40);

    // LUI / ADDI sign-extension program
    prog = '{32'h000015b7, 32'h80000637, 32'hfffff6b7, 32'h00150713,
             32'h00158793, 32'h00a60813, 32'h00a68893, 32'h0000006f};
    load_prog(12'd0);
    pulse_reset();
    do_start(20'd0);
    tick(50);
    for (int i = 0; i < 32; i++) exp_regs[i] = 32'd0;
    exp_regs[11] = 32'h00001000; exp_regs[12] = 32'h80000000; exp_regs[13] = 32'hfffff000;
    exp_regs[14] = 32'h00000001; exp_regs[15] = 32'h00001001; exp_regs[16] = 32'h8000000a;
    exp_regs[17] = 32'hfffff00a;
    for (int i = 0; i < 32; i++)
      check($sformatf("lui_addi_x%0d", i), dut.register_file[i], exp_regs[i]);

    // back-to-back dependencies, one write per cycle, restart while running
    prog = '{32'h00500093, 32'h00108133, 32'h401101b3, 32'h0000006f};
    load_prog(12'd0);
    do_start(20'd0);
    tick(2);
    check("dep_x1_at_e2", dut.register_file[1], 32'd5);
    check("dep_x2_before", dut.register_file[2], 32'd0);
    tick(1);
    check("dep_x2_at_e3", dut.register_file[2], 32'd10);
    check("dep_x3_before", dut.register_file[3], 32'd0);
    tick(1);
    check("dep_x3_at_e4", dut.register_file[3], 32'd5);

    // store/load, x0 write discard, address wrap above the memory range
    prog = '{32'h00700093, 32'h00102423, 32'h00802103, 32'h00300013,
             32'h00004237, 32'h00822183, 32'h0000006f};
    load_prog(12'd0);
    do_start(20'd0);
    tick(30);
    check("sw_lw_x2", dut.register_file[2], 32'd7);
    check("x0_stays_zero", dut.register_file[0], 32'd0);
    check("lui_x4", dut.register_file[4], 32'h00004000);
    check("lw_wrap_x3", dut.register_file[3], 32'd7);

    // taken branch and JAL flush the fetched instruction
    prog = '{32'h00000463, 32'h00100293, 32'h00200313, 32'h008003ef,
             32'h00900413, 32'h00300493, 32'h0000006f};
    load_prog(12'd0);
    do_start(20'd0);
    tick(30);
    check("beq_skip_x5", dut.register_file[5], 32'd0);
    check("beq_target_x6", dut.register_file[6], 32'd2);
    check("jal_link_x7", dut.register_file[7], 32'd16);
    check("jal_skip_x8", dut.register_file[8], 32'd0);
    check("jal_target_x9", dut.register_file[9], 32'd3);

    // shifts, compares, logic, not-taken BLTU, AUIPC, JALR
    prog = '{32'hff800513, 32'h40155593, 32'h01c55613, 32'h00c526b3,
             32'h00c53733, 32'h00c547b3, 32'h00c61833, 32'h00c56463,
             32'h00001897, 32'h03000967, 32'h00100993, 32'h00200993,
             32'h00c5ea33, 32'h0000006f};
    load_prog(12'd0);
    do_start(20'd0);
    tick(40);
    check("addi_neg_x10", dut.register_file[10], 32'hfffffff8);
    check("srai_x11", dut.register_file[11], 32'hfffffffc);
    check("srli_x12", dut.register_file[12], 32'h0000000f);
    check("slt_x13", dut.register_file[13], 32'd1);
    check("sltu_x14", dut.register_file[14], 32'd0);
    check("xor_x15", dut.register_file[15], 32'hfffffff7);
    check("sll_x16", dut.register_file[16], 32'h00078000);
    check("auipc_x17", dut.register_file[17], 32'h00001020);
    check("jalr_link_x18", dut.register_file[18], 32'd40);
    check("jalr_skip_x19", dut.register_file[19], 32'd0);
    check("or_x20", dut.register_file[20], 32'hffffffff);

    // load while idle, then start at byte 0x40 (word 16)
    pulse_reset();
    check("idle_after_reset", {31'd0, dut.r_running}, 32'd0);
    prog = '{32'h00100b13, 32'h05500a93, 32'h0000006f};
    load_prog(12'd15);
    do_start(20'h00040);
    tick(20);
    check("start_word16_x21", dut.register_file[21], 32'h00000055);
    check("start_word16_x22", dut.register_file[22], 32'd0);

    // reset mid-loop aborts the addi sitting in EX
    prog = '{32'h001b8b93, 32'hffdff06f};
    load_prog(12'd32);
    do_start(20'h00080);
    tick(7);
    #2 reset = 1'b1;
    #1;
    check("midreset_pc", dut.r_pc, 32'd0);
    check("midreset_running", {31'd0, dut.r_running}, 32'd0);
    tick(3);
    reset = 1'b0;
    tick(20);
    check("midreset_x23", dut.register_file[23], 32'd2);
    check("midreset_pc_idle", dut.r_pc, 32'd0);
    check("midreset_cycles", dut.r_cycle_count, 32'd0);
    check("midreset_retired", dut.r_retired_count, 32'd0);
    check_outputs("midreset_outputs");
    do_start(20'h00080);
    tick(3);
    check("restart_x23", dut.register_file[23], 32'd3);

    report = 1'b1;
    tick(1);
    report = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
